// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling geometry and the
// majority-vote helper used at mid-bit.
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;

  // Oversample indices around mid-bit that feed the 2-of-3 vote
  localparam logic [3:0] VOTE_S0 = 4'd7;
  localparam logic [3:0] VOTE_S1 = 4'd8;
  localparam logic [3:0] VOTE_S2 = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } uart_state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: one-cycle tick every CLK_DIV clocks, with a
// synchronous clear so sampling phase can be re-aligned to a detected edge.
module uart_tick_gen #(
  parameter int CLK_DIV = 65
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)    r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  assign tick = (r_cnt == LAST) && !clear;

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: 16x oversampling with mid-bit majority vote, feeding a
// one-deep valid/ready output register with frame-error and overrun pulses.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_DIV = 65
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam logic [3:0] SCNT_LAST = 4'(UART_OVERSAMPLE - 1);
  localparam logic [2:0] IDX_LAST  = 3'(UART_DATA_BITS - 1);

  logic        r_sync1, r_rxs;
  uart_state_t r_state;
  logic [3:0]  r_scnt;
  logic [2:0]  r_idx;
  logic [7:0]  r_shift;
  logic        r_s7, r_s8;
  logic        r_ferr, r_ovr, r_valid;
  logic [7:0]  r_data;

  logic w_start, w_tick, w_vote, w_vote_tick, w_push;

  assign w_start     = (r_state == S_IDLE) && !r_rxs;
  assign w_vote      = maj3(r_s7, r_s8, r_rxs);
  assign w_vote_tick = w_tick && (r_scnt == VOTE_S2);
  assign w_push      = (r_state == S_STOP) && w_vote_tick && w_vote;

  uart_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .tick  (w_tick)
  );

  // Idle-high synchronizer so reset never looks like a start bit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_s7    <= 1'b0;
      r_s8    <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      if (w_tick && r_state != S_IDLE) begin
        r_scnt <= r_scnt + 1'b1;
        if (r_scnt == VOTE_S0) r_s7 <= r_rxs;
        if (r_scnt == VOTE_S1) r_s8 <= r_rxs;
      end
      case (r_state)
        S_IDLE: if (!r_rxs) begin
          r_state <= S_START;
          r_scnt  <= '0;
        end
        S_START: begin
          if (w_vote_tick && w_vote) r_state <= S_IDLE;
          else if (w_tick && r_scnt == SCNT_LAST) begin
            r_state <= S_DATA;
            r_idx   <= '0;
          end
        end
        S_DATA: begin
          if (w_vote_tick) r_shift[r_idx] <= w_vote;
          if (w_tick && r_scnt == SCNT_LAST) begin
            if (r_idx == IDX_LAST) r_state <= S_STOP;
            else                   r_idx   <= r_idx + 1'b1;
          end
        end
        // Re-arm at mid-stop so a back-to-back start edge is not missed
        S_STOP: if (w_vote_tick) begin
          if (w_vote) r_state <= S_IDLE;
          else begin
            r_ferr  <= 1'b1;
            r_state <= S_WAIT_IDLE;
          end
        end
        S_WAIT_IDLE: if (r_rxs) r_state <= S_IDLE;
        default:     r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_push) begin
        if (!r_valid || ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Scoreboard bench for uart_byte_receiver: a serial-line driver plus a frame-level
// model push expected bytes/pulses; a monitor pops and compares on each accept.
module tb_uart_byte_receiver;

  localparam int CLK_DIV = 4;
  localparam int BIT     = 16 * CLK_DIV;

  logic       clk = 1'b0, reset = 1'b1, rx = 1'b1, ready = 1'b1;
  logic [7:0] data;
  logic       valid, frame_err, overrun, busy;

  uart_byte_receiver #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_checks = 0, n_pass = 0;
  int         n_ferr = 0, n_ovr = 0, exp_ferr = 0, exp_ovr = 0;
  int         t_edge = 0, t_valid = 0;
  logic       valid_q = 1'b0, m_held = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Inputs change 2 ns after each rising edge; outputs are read on falling edges
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
    rx = 1'b0; t_edge = cyc; step(per);
    for (int i = 0; i < 8; i++) begin rx = b[i]; step(per); end
    rx = stop_bit; step(per);
  endtask

  // What a correct receiver must produce for one frame, given the consumer state
  function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
    if (!stop_ok)    exp_ferr++;
    else if (m_held) exp_ovr++;
    else begin
      exp_q.push_back(b);
      if (!ready) m_held = 1'b1;
    end
  endfunction

  always @(negedge clk) begin
    if (valid && !valid_q) t_valid = cyc;
    valid_q = valid;
    if (frame_err) n_ferr++;
    if (overrun)   n_ovr++;
    if (valid && ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got 0x%0h, expected no byte", data);
      end else begin
        chk("rx_byte", {24'd0, data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       bad;
    int         per, gap, lat;

    step(4);
    chk("reset_valid", valid, 0);
    chk("reset_data", data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ferr_ovr", {frame_err, overrun}, 0);
    reset = 1'b0;
    step(2 * BIT);

    // Clean frame with a ready consumer, plus edge-to-valid latency
    model_frame(8'h55, 1'b1);
    send_frame(8'h55, 1'b1, BIT);
    lat = t_valid - t_edge;
    n_checks++;
    if (lat >= 618 && lat <= 620) n_pass++;
    else $display("FAIL edge_to_valid: got %0d clk, expected 619 +/- 1", lat);
    chk("busy_after_stop", busy, 0);
    chk("valid_one_cycle", valid, 0);
    step(2 * BIT);

    // Back-to-back frames into a stalled consumer
    ready = 1'b0;
    model_frame(8'hA3, 1'b1);
    send_frame(8'hA3, 1'b1, BIT);
    model_frame(8'h0F, 1'b1);
    send_frame(8'h0F, 1'b1, BIT);
    step(BIT);
    chk("held_valid", valid, 1);
    chk("held_data", data, exp_q[0]);
    chk("overrun_count", n_ovr, exp_ovr);
    ready = 1'b1; step(1); ready = 1'b0; m_held = 1'b0;
    chk("valid_after_accept", valid, 0);
    ready = 1'b1;
    step(2 * BIT);

    // Bad stop bit followed by a long break, then recovery
    model_frame(8'h3C, 1'b0);
    send_frame(8'h3C, 1'b0, BIT);
    step(20 * BIT);
    chk("break_busy", busy, 1);
    chk("break_single_ferr", n_ferr, exp_ferr);
    rx = 1'b1; step(2 * BIT);
    chk("break_recovered", busy, 0);
    model_frame(8'h81, 1'b1);
    send_frame(8'h81, 1'b1, BIT);
    step(2 * BIT);

    // Short glitch must be rejected as a false start
    rx = 1'b0; step(10);
    chk("glitch_busy", busy, 1);
    step(14); rx = 1'b1; step(40);
    chk("glitch_idle", busy, 0);
    chk("glitch_no_ferr", n_ferr, exp_ferr);
    step(2 * BIT);

    // Reset mid-frame (inside data bit 5, after which the line stays high)
    fork
      send_frame(8'hE7, 1'b1, BIT);
      begin
        step(6 * BIT + BIT / 2);
        reset = 1'b1; step(1);
        chk("midreset_outputs", {valid, frame_err, overrun, busy}, 0);
        chk("midreset_data", data, 0);
        reset = 1'b0;
      end
    join
    step(2 * BIT);
    model_frame(8'h42, 1'b1);
    send_frame(8'h42, 1'b1, BIT);
    step(BIT);
    chk("after_reset_data", data, 8'h42);

    // Baud mismatch at both ends of the tolerance
    model_frame(8'h99, 1'b1);
    send_frame(8'h99, 1'b1, 62);
    step(2 * BIT);
    model_frame(8'h99, 1'b1);
    send_frame(8'h99, 1'b1, 66);
    step(BIT);
    chk("baud_no_ferr", n_ferr, exp_ferr);

    // Random traffic: random bytes, rates and gaps, occasional framing errors
    for (int i = 0; i < 16; i++) begin
      b   = 8'($urandom);
      per = $urandom_range(62, 66);
      bad = ($urandom_range(0, 7) == 0);
      model_frame(b, !bad);
      send_frame(b, !bad, per);
      gap = bad ? $urandom_range(1, 2) : $urandom_range(0, 2);
      rx = 1'b1;
      step(gap * per);
    end
    step(3 * BIT);

    chk("pending_bytes", exp_q.size(), 0);
    chk("final_ferr_count", n_ferr, exp_ferr);
    chk("final_ovr_count", n_ovr, exp_ovr);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_byte_receiver.md
# uart_byte_receiver

Board-side UART receiver for the Marsohod3 top level. It converts the asynchronous serial stream arriving on a board IO pin into bytes, using 8N1 framing, LSB first. It is the receive-direction counterpart of the `UART_TX` line driven by `mfp_system`. It runs in the `clk10m` domain and presents each byte on a one-deep valid/ready output register, for a board-side consumer such as LED debug or a loopback checker.

## Interface
- `CLK_DIV`, default 65: clk cycles per oversample tick, must be ≥ 2. 65 gives 9600 baud × 16 from 10 MHz (0.16 % error).
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  raw asynchronous serial input; idle level is 1.
- `data`  out  8  received byte, valid while `valid` = 1.
- `valid`  out  1  byte available; held until accepted.
- `ready`  in  1  consumer accepts the byte when `valid && ready` at a rising edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: new byte dropped because the output register was still full.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Synchronizer:
  - Two-flop synchronizer on `rx`; both flops reset to 1.
  - All logic below uses the synchronized value `rxs`.
- Tick generator:
  - Counter runs 0..CLK_DIV-1; `tick` is asserted for one cycle when the count equals CLK_DIV-1.
  - Counter is forced to 0 on the IDLE→START transition, which aligns sampling to the detected edge.
- Sample counter:
  - `scnt` runs 0..15 and advances on `tick`; a bit period is 16 ticks.
  - Samples taken at scnt = 7, 8 and 9 are majority-voted.
  - The vote result is registered at the scnt = 9 tick (the "vote tick").
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: `rxs` = 0 → START, with scnt = 0.
  - START, at vote tick:
    - vote = 1: false start, return to IDLE with no output.
    - vote = 0: stay in START until scnt wraps 15→0, then go to DATA with bit index 0.
  - DATA: at each vote tick, shift the vote into bit[idx] (LSB first). After idx 7 completes its 16 ticks → STOP.
  - STOP, at vote tick:
    - vote = 1: push the byte and go to IDLE.
    - vote = 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: stay until `rxs` = 1, then go to IDLE. A break condition therefore produces exactly one `frame_err`.
- Output register:
  - Push with `valid` = 0: load `data`, set `valid`.
  - Push with `valid && ready` in the same cycle: load the new byte, `valid` stays 1, no overrun.
  - Push with `valid && !ready`: keep the old byte, pulse `overrun`.
  - `valid && ready` with no push: clear `valid`. `data` keeps its last value.
- Reset values:
  - `data` = 0x00.
  - `valid`, `frame_err`, `overrun` and `busy` = 0.
  - FSM in IDLE, all counters 0.
- Reset mid-frame aborts the frame with no output. If `rx` is still low when reset releases, IDLE sees `rxs` = 0 and starts a frame. That frame normally fails on its stop bit and yields one `frame_err`, then recovers.

## Timing
- `rx` falling edge to `rxs` = 0: 2–3 clk.
- One bit period is 16·CLK_DIV clk.
- Start bit is validated at 10 ticks after edge detection.
- The push happens at the stop-bit vote tick.
  - `valid` rises the next clk edge.
  - `frame_err` pulses in that same cycle instead.
- Edge to `valid`: 9·16·CLK_DIV + 10·CLK_DIV + 3 ± 1 clk. With CLK_DIV = 4 this is 619 ± 1 clk.
- Back-to-back frames are accepted: re-arming happens at the mid-stop vote, so the next start edge is detected with no dead time.
- Tolerated baud mismatch: ±3 %.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `UART_OVERSAMPLE` = 16, `UART_DATA_BITS` = 8.
  - Vote sample indices 7/8/9.
- Sub-module `uart_tick_gen`: the CLK_DIV counter with `clear` input and `tick` output. It is reusable by a future TX block.
- Top: synchronizer, FSM, shift register, output register.

## Test plan (CLK_DIV = 4, bit = 64 clk)
- Send 0x55, 8N1, `ready` = 1 → `valid` for 1 cycle, `data` = 0x55, no error pulses, `busy` low after the stop vote.
- Send 0xA3 then 0x0F back-to-back with `ready` = 0 until the end → `data` = 0xA3 held, one `overrun` pulse at the second stop; pulse `ready` → `valid` = 0.
- Send 0x3C with stop bit = 0 → one `frame_err`, no `valid`; hold `rx` = 0 for 20 bits → still only one `frame_err`; release → next byte 0x81 received correctly.
- Glitch `rx` low for 24 clk (6 ticks) → no output, FSM back in IDLE, `busy` = 0.
- Assert `reset` for 1 cycle mid-DATA of 0xE7 → all outputs 0; next frame 0x42 received with `data` = 0x42.
- Send 0x99 at +3 % and −3 % bit period (62/66 clk) → `data` = 0x99, no `frame_err`.
